// File: rtl/frame_write_packer.sv
// Byte-to-word packer feeding the DDR2 write multiplexer.
// Assembles bytes into wide words and issues each as a one-cycle write strobe.
module frame_write_packer #(
  parameter int                WORD_BYTES  = 96,
  parameter int                FRAME_WORDS = 8,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(8)
) (
  input  logic                    clk0_tb,
  input  logic                    rst0_tb,
  input  logic                    frame_start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    ram_ready,
  output logic [8*WORD_BYTES-1:0] write_data,
  output logic [ADDR_W-1:0]       write_address,
  output logic                    write_ram,
  output logic                    new_frame,
  output logic                    frame_ovf
);

  localparam int DW  = 8*WORD_BYTES;
  localparam int BCW = $clog2(WORD_BYTES);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic {EMPTY, PEND} state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [BCW-1:0] eff_cnt;
  logic [WCW-1:0] word_cnt;
  logic [WCW-1:0] eff_wcnt;
  logic [DW-1:0]  asm_q;
  logic [DW-1:0]  asm_next;
  logic           pend_last;
  logic           wrap_q;
  logic           last_slot;
  logic           accept;
  logic           done;
  logic           word_end;

  // frame_start makes a same-cycle byte land in slot 0 of a fresh frame
  always_comb begin
    last_slot = byte_cnt == BCW'(WORD_BYTES-1);
    in_ready  = !(state == PEND && (last_slot || in_last));
    accept    = in_valid && in_ready;
    eff_cnt   = frame_start ? '0 : byte_cnt;
    eff_wcnt  = frame_start ? '0 : word_cnt;
    asm_next  = frame_start ? '0 : asm_q;
    asm_next[8*eff_cnt +: 8] = in_data;
    done      = accept &&
                (eff_cnt == BCW'(WORD_BYTES-1) || in_last);
    word_end  = eff_wcnt == WCW'(FRAME_WORDS-1);
  end

  always_ff @(posedge clk0_tb) begin
    if (rst0_tb) begin
      state         <= EMPTY;
      write_ram     <= 1'b0;
      new_frame     <= 1'b0;
      frame_ovf     <= 1'b0;
      write_data    <= '0;
      write_address <= BASE_ADDR;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      asm_q         <= '0;
      pend_last     <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      write_ram <= 1'b0;
      new_frame <= 1'b0;
      if (state == PEND && ram_ready) begin
        write_ram <= 1'b1;
        new_frame <= pend_last;
        state     <= EMPTY;
      end
      if (frame_start) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        asm_q    <= '0;
        wrap_q   <= 1'b0;
      end
      if (accept) begin
        // first byte after a frame ran out of words without in_last
        if (wrap_q && !frame_start)
          frame_ovf <= 1'b1;
        wrap_q <= 1'b0;
        if (done) begin
          state         <= PEND;
          write_data    <= asm_next;
          write_address <= BASE_ADDR + ADDR_W'(eff_wcnt) * ADDR_STEP;
          pend_last     <= in_last || word_end;
          word_cnt      <= (in_last || word_end) ? '0 : eff_wcnt + 1'b1;
          wrap_q        <= word_end && !in_last;
          byte_cnt      <= '0;
          asm_q         <= '0;
        end else begin
          asm_q    <= asm_next;
          byte_cnt <= eff_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_write_packer.sv
// Randomized scoreboard bench for frame_write_packer.
// A byte-list reference model predicts every write strobe.
module tb_frame_write_packer;

  localparam int WB = 96;
  localparam int FW = 8;
  localparam int DW = 8*WB;

  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   a;
    logic          nf;
  } exp_t;

  logic          clk0_tb = 0;
  logic          rst0_tb = 1;
  logic          frame_start = 0;
  logic [7:0]    in_data = 0;
  logic          in_valid = 0;
  logic          in_last = 0;
  logic          in_ready;
  logic          ram_ready = 0;
  logic [DW-1:0] write_data;
  logic [31:0]   write_address;
  logic          write_ram;
  logic          new_frame;
  logic          frame_ovf;

  int   tests = 0;
  int   fails = 0;
  bit   rr_rand = 0;
  exp_t exp_q[$];
  logic [7:0] cur[$];
  int   widx = 0;
  bit   wrapped = 0;
  bit   ovf_exp = 0;

  frame_write_packer dut (
    .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .frame_start(frame_start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .ram_ready(ram_ready),
    .write_data(write_data), .write_address(write_address),
    .write_ram(write_ram), .new_frame(new_frame), .frame_ovf(frame_ovf)
  );

  always #5 clk0_tb = ~clk0_tb;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: bytes collected per word, word index per frame
  task automatic model_byte(input logic [7:0] b, input logic l);
    exp_t e;
    if (wrapped) begin
      ovf_exp = 1;
      wrapped = 0;
    end
    cur.push_back(b);
    if (cur.size() == WB || l) begin
      e.d = '0;
      foreach (cur[i]) e.d[8*i +: 8] = cur[i];
      e.a  = 32'(widx * 8);
      e.nf = l || (widx == FW-1);
      if (widx == FW-1 && !l) wrapped = 1;
      widx = e.nf ? 0 : widx + 1;
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l, output int waited);
    in_valid = 1;
    in_data  = b;
    in_last  = l;
    waited   = 0;
    forever begin
      #1;
      if (in_ready) break;
      @(negedge clk0_tb);
      waited++;
      if (waited > 2000) break;
    end
    if (waited > 2000) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got=stall want=accept");
    end else begin
      @(negedge clk0_tb);
      model_byte(b, l);
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic send_n(input int n, input bit with_last);
    int w;
    for (int i = 0; i < n; i++)
      send(8'($urandom), with_last && (i == n-1), w);
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk0_tb);
      c++;
    end
    chk("drain", DW'(exp_q.size()), '0);
    repeat (3) @(negedge clk0_tb);
  endtask

  task automatic do_reset();
    @(negedge clk0_tb);
    rst0_tb = 1;
    exp_q.delete();
    cur.delete();
    widx = 0;
    wrapped = 0;
    ovf_exp = 0;
    repeat (2) @(negedge clk0_tb);
    rst0_tb = 0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk0_tb);
      if (!rst0_tb && write_ram) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe got=%h want=none", write_address);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", write_data, e.d);
          chk("waddr", DW'(write_address), DW'(e.a));
          chk("new_frame", DW'(new_frame), DW'(e.nf));
        end
      end else if (!rst0_tb && new_frame) begin
        chk("nf_no_strobe", DW'(new_frame), '0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk0_tb);
      if (rr_rand) ram_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk0_tb);
    chk("rst_write_ram", DW'(write_ram), '0);
    chk("rst_new_frame", DW'(new_frame), '0);
    chk("rst_frame_ovf", DW'(frame_ovf), '0);
    chk("rst_write_data", write_data, '0);
    chk("rst_write_addr", DW'(write_address), '0);
    rst0_tb = 0;
    @(negedge clk0_tb);
    #1 chk("rst_in_ready", DW'(in_ready), DW'(1));

    // ascending full word
    ram_ready = 1;
    for (int i = 0; i < WB; i++) send(8'(i), 0, w);
    drain();

    // full frame terminated by in_last
    do_reset();
    ram_ready = 1;
    send_n(FW*WB, 1);
    drain();
    chk("ovf_after_frame", DW'(frame_ovf), DW'(ovf_exp));

    // short frame, then new frame restarts at 0
    for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), i == 9, w);
    send_n(WB, 0);
    drain();

    // backpressure: pending word plus a second word being fed
    ram_ready = 0;
    send_n(WB, 0);
    for (int i = 0; i < WB-1; i++) begin
      send(8'($urandom), 0, w);
      chk("no_stall", DW'(w), '0);
    end
    fork
      send(8'($urandom), 0, w);
      begin
        repeat (50) @(negedge clk0_tb);
        ram_ready = 1;
      end
    join
    chk("stall_held", DW'(w >= 50), DW'(1));
    drain();

    // overflow: nine words without in_last, random ram_ready
    rr_rand = 1;
    send_n((FW+1)*WB - widx*WB, 0);
    drain();
    chk("ovf_set", DW'(frame_ovf), DW'(ovf_exp));
    send_n(10, 1);
    drain();
    chk("ovf_sticky", DW'(frame_ovf), DW'(1));
    rr_rand = 0;

    // reset discards pending and partial words
    ram_ready = 0;
    send_n(WB, 0);
    send_n(40, 0);
    do_reset();
    ram_ready = 1;
    repeat (10) @(negedge clk0_tb);
    chk("ovf_cleared", DW'(frame_ovf), '0);
    send_n(WB, 0);
    drain();

    // frame_start while a word is pending
    ram_ready = 0;
    send_n(WB, 0);
    send_n(20, 0);
    frame_start = 1;
    @(negedge clk0_tb);
    frame_start = 0;
    cur.delete();
    widx = 0;
    wrapped = 0;
    ram_ready = 1;
    send_n(WB, 0);
    drain();

    chk("final_queue", DW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
